alu_exec: RTL and testbench

//  Execute stage directly downstream of the register file. Consumes op1/op2 read

---
 rtl/alu_exec_pkg.sv | 42 ++++
 rtl/alu_exec_muldiv_iter.sv | 108 ++++++++++
 rtl/alu_exec.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_exec.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg
//   Shared definitions for the execute stage: datapath defaults, opcode
//   encodings, FSM state encoding and the opcode legality helper.
//   Build option: ALU_EXEC_DIV_EN (when defined, opcode 9 / DIV is legal and
//   the divider datapath is built; otherwise DIV decodes as illegal).
package alu_exec_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int REGADDR_DEF = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SRA = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_DIV = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } stateT;

  // True for every opcode this build executes.
  function automatic logic isLegalOp(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SLL, OP_SRL, OP_SRA, OP_MUL: legal = 1'b1;
`ifdef ALU_EXEC_DIV_EN
      OP_DIV:                          legal = 1'b1;
`endif
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_exec_muldiv_iter.sv
// muldiv_iter
//   Iterative unsigned multiply / restoring divide core, one bit per step.
//   Holds the accumulator (hi), the shift register (lo), the latched divisor /
//   multiplicand and the step counter.
//   Build option: ALU_EXEC_DIV_EN (divide step is only built when defined;
//   otherwise isDiv is ignored and the core always multiplies).
// Ports
//   clk, reset : clock, synchronous active-high reset
//   load       : capture a, b, isDiv and clear accumulator/counter
//   isDiv      : 1 = divide a / b, 0 = multiply a * b (sampled at load)
//   a, b       : operands (sampled at load)
//   step       : perform one iteration (ignored once last is set)
//   lo, hi     : product low/high, or quotient/remainder
//   last       : all ITERS steps have been performed; lo/hi are final
module muldiv_iter
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);

  localparam int CNTW = $clog2(ITERS + 1);

  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] loNext;
  logic [WIDTH-1:0] hiNext;
  logic [CNTW-1:0]  cntReg;
  logic             lastReg;
  logic [WIDTH:0]   mulSum;

`ifdef ALU_EXEC_DIV_EN
  logic             isDivReg;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;
`else
  logic             unusedIsDiv;
  assign unusedIsDiv = isDiv;
`endif

  always_comb begin
    // Shift-add: add the multiplicand when the current multiplier bit is set,
    // then shift {carry, hi, lo} right one place. Multiplier bits are consumed
    // from lo[0] while product bits enter lo from the top.
    mulSum = {1'b0, hiReg} + (loReg[0] ? {1'b0, bReg} : '0);
    hiNext = mulSum[WIDTH:1];
    loNext = {mulSum[0], loReg[WIDTH-1:1]};
`ifdef ALU_EXEC_DIV_EN
    // Restoring divide: bring the next dividend bit into the remainder and try
    // subtracting the divisor. Bit WIDTH of the difference is the borrow.
    remShift = {hiReg, loReg[WIDTH-1]};
    remDiff  = remShift - {1'b0, bReg};
    if (isDivReg) begin
      if (remDiff[WIDTH]) begin
        hiNext = remShift[WIDTH-1:0];
        loNext = {loReg[WIDTH-2:0], 1'b0};
      end else begin
        hiNext = remDiff[WIDTH-1:0];
        loNext = {loReg[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loReg   <= '0;
      hiReg   <= '0;
      bReg    <= '0;
      cntReg  <= '0;
      lastReg <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      isDivReg <= 1'b0;
`endif
    end else if (load) begin
      loReg   <= a;
      hiReg   <= '0;
      bReg    <= b;
      cntReg  <= '0;
      lastReg <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      isDivReg <= isDiv;
`endif
    end else if (step && !lastReg) begin
      loReg   <= loNext;
      hiReg   <= hiNext;
      cntReg  <= cntReg + CNTW'(1);
      lastReg <= (cntReg == CNTW'(ITERS - 1));
    end
  end

  assign lo   = loReg;
  assign hi   = hiReg;
  assign last = lastReg;

endmodule

// File: rtl/alu_exec.sv
// alu_exec
//   Execute stage behind the register file. Accepts one operation at a time
//   (start while idle), runs it through the single-cycle ALU or the iterative
//   mul/div core, and returns the result to the register file write port.
//   Build option: ALU_EXEC_DIV_EN (DIV support; when undefined opcode 9 is
//   illegal, no divider is built and divZero stays 0).
// Ports
//   clk, reset          : clock, synchronous active-high reset (aborts any op)
//   start               : request, accepted only when busy is low
//   aluOp, op1, op2     : opcode and operands, sampled at accept
//   destReg             : destination register, sampled at accept
//   busy                : an operation is in progress (FSM not idle)
//   done                : one-cycle completion pulse
//   wrData, resultHi    : result low/quotient, product high/remainder
//   RegWrite, wrReg     : register file write strobe and address
//   zero, ovf, divZero, illegal : status flags, held until the next done
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int REGADDR = REGADDR_DEF,
  parameter int ITERS   = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         aluOp,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [REGADDR-1:0] destReg,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   wrData,
  output logic [WIDTH-1:0]   resultHi,
  output logic               RegWrite,
  output logic [REGADDR-1:0] wrReg,
  output logic               zero,
  output logic               ovf,
  output logic               divZero,
  output logic               illegal
);

  stateT stateReg;
  stateT stateNext;

  // Output registers
  logic               doneReg;
  logic               regWriteReg;
  logic [WIDTH-1:0]   wrDataReg;
  logic [WIDTH-1:0]   resultHiReg;
  logic [REGADDR-1:0] wrRegReg;
  logic               zeroReg;
  logic               ovfReg;
  logic               divZeroReg;
  logic               illegalReg;
  logic [REGADDR-1:0] destLatched;

  // Decode of the request on the input port
  logic opIllegal;
  logic isMul;
  logic isDivOp;
  logic divByZero;
  logic isLongOp;

  // Single-cycle ALU
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] subB;
  logic             aluOvf;
  logic [3:0]       shamt;

  // FSM controls
  logic coreLoad;
  logic coreStep;
  logic finish;
  logic useCore;

  // Result about to be registered at finish
  logic [WIDTH-1:0]   resLo;
  logic [WIDTH-1:0]   resHi;
  logic [REGADDR-1:0] resReg;
  logic               resWrite;
  logic               resOvf;
  logic               resDivZero;
  logic               resIllegal;

  // Iterative core
  logic [WIDTH-1:0] coreLo;
  logic [WIDTH-1:0] coreHi;
  logic             coreLast;

  always_comb begin
    opIllegal = !isLegalOp(aluOp);
    isMul     = (aluOp == OP_MUL);
`ifdef ALU_EXEC_DIV_EN
    isDivOp   = (aluOp == OP_DIV);
    divByZero = isDivOp && (op2 == '0);
`else
    isDivOp   = 1'b0;
    divByZero = 1'b0;
`endif
    // Divide by zero is answered on the single-cycle path.
    isLongOp  = isMul || (isDivOp && !divByZero);
  end

  always_comb begin
    aluRes = '0;
    aluOvf = 1'b0;
    subB   = ~op2;
    shamt  = op2[3:0];
    case (aluOp)
      OP_ADD: begin
        aluRes = op1 + op2;
        aluOvf = (op1[WIDTH-1] == op2[WIDTH-1]) && (aluRes[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = op1 - op2;
        aluOvf = (op1[WIDTH-1] == subB[WIDTH-1]) && (aluRes[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_AND:  aluRes = op1 & op2;
      OP_OR:   aluRes = op1 | op2;
      OP_SLL:  aluRes = op1 << shamt;
      OP_SRL:  aluRes = op1 >> shamt;
      OP_SRA:  aluRes = WIDTH'($signed(op1) >>> shamt);
      default: aluRes = '0;
    endcase
  end

  // Next state. While iterating, the core steps until it raises last; the
  // cycle after the final step only moves the core result into the output
  // registers, which is why a long op completes ITERS+1 edges after accept.
  always_comb begin
    stateNext = stateReg;
    coreLoad  = 1'b0;
    coreStep  = 1'b0;
    finish    = 1'b0;
    useCore   = 1'b0;
    case (stateReg)
      ST_IDLE: begin
        if (start) begin
          if (isLongOp) begin
            stateNext = ST_ITER;
            coreLoad  = 1'b1;
          end else begin
            stateNext = ST_DONE;
            finish    = 1'b1;
          end
        end
      end
      ST_ITER: begin
        if (coreLast) begin
          stateNext = ST_DONE;
          finish    = 1'b1;
          useCore   = 1'b1;
        end else begin
          coreStep = 1'b1;
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Result selection. An illegal op keeps wrData/resultHi/wrReg and raises
  // only the illegal flag; every other flag is recomputed at each done.
  always_comb begin
    resLo      = wrDataReg;
    resHi      = resultHiReg;
    resReg     = wrRegReg;
    resWrite   = 1'b0;
    resOvf     = 1'b0;
    resDivZero = 1'b0;
    resIllegal = 1'b0;
    if (useCore) begin
      resLo    = coreLo;
      resHi    = coreHi;
      resReg   = destLatched;
      resWrite = 1'b1;
    end else if (opIllegal) begin
      resIllegal = 1'b1;
    end else if (divByZero) begin
      resLo      = '1;
      resHi      = op1;
      resReg     = destReg;
      resWrite   = 1'b1;
      resDivZero = 1'b1;
    end else begin
      resLo    = aluRes;
      resHi    = '0;
      resReg   = destReg;
      resWrite = 1'b1;
      resOvf   = aluOvf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= ST_IDLE;
      doneReg     <= 1'b0;
      regWriteReg <= 1'b0;
      wrDataReg   <= '0;
      resultHiReg <= '0;
      wrRegReg    <= '0;
      zeroReg     <= 1'b0;
      ovfReg      <= 1'b0;
      divZeroReg  <= 1'b0;
      illegalReg  <= 1'b0;
      destLatched <= '0;
    end else begin
      stateReg    <= stateNext;
      doneReg     <= finish;
      regWriteReg <= finish && resWrite;
      if (coreLoad) begin
        destLatched <= destReg;
      end
      if (finish) begin
        wrDataReg   <= resLo;
        resultHiReg <= resHi;
        wrRegReg    <= resReg;
        zeroReg     <= (resLo == '0);
        ovfReg      <= resOvf;
        divZeroReg  <= resDivZero;
        illegalReg  <= resIllegal;
      end
    end
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) uCore (
    .clk   (clk),
    .reset (reset),
    .load  (coreLoad),
    .isDiv (isDivOp),
    .a     (op1),
    .b     (op2),
    .step  (coreStep),
    .lo    (coreLo),
    .hi    (coreHi),
    .last  (coreLast)
  );

  assign busy     = (stateReg != ST_IDLE);
  assign done     = doneReg;
  assign RegWrite = regWriteReg;
  assign wrData   = wrDataReg;
  assign resultHi = resultHiReg;
  assign wrReg    = wrRegReg;
  assign zero     = zeroReg;
  assign ovf      = ovfReg;
  assign divZero  = divZeroReg;
  assign illegal  = illegalReg;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec
//   Directed bench for alu_exec. A behavioural model computes each op's
//   result and completion latency from plain arithmetic; a per-cycle compare
//   process checks every output against it, and the directed vectors also
//   carry hand-computed literals. Honours ALU_EXEC_DIV_EN like the design.
module tb_alu_exec;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  dest;
    logic        wr;
    logic        zero;
    logic        ovf;
    logic        dz;
    logic        ill;
    logic [4:0]  lat;
  } expT;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  aluOp;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [3:0]  destReg;
  logic        busy;
  logic        done;
  logic [15:0] wrData;
  logic [15:0] resultHi;
  logic        RegWrite;
  logic [3:0]  wrReg;
  logic        zero;
  logic        ovf;
  logic        divZero;
  logic        illegal;

  int  nChecks = 0;
  int  nFails  = 0;
  bit  checkEn;
  bit  active;
  bit  acceptFlag;
  int  phase;
  expT heldE;
  expT pendE;
  expT lastE;

  alu_exec dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .aluOp    (aluOp),
    .op1      (op1),
    .op2      (op2),
    .destReg  (destReg),
    .busy     (busy),
    .done     (done),
    .wrData   (wrData),
    .resultHi (resultHi),
    .RegWrite (RegWrite),
    .wrReg    (wrReg),
    .zero     (zero),
    .ovf      (ovf),
    .divZero  (divZero),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what the register file port must show after the op completes,
  // given what it showed before.
  function automatic expT model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] d, input expT prev);
    expT    e;
    int     sa;
    int     sb;
    int     sr;
    longint prod;
    e     = prev;
    e.wr  = 1'b0;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    e.ill = 1'b0;
    e.lat = 5'd0;
    sa    = $signed(a);
    sb    = $signed(b);
    case (op)
      4'h0: begin sr = sa + sb; e.lo = 16'(sr); e.hi = 16'h0; e.ovf = (sr > 32767) || (sr < -32768); end
      4'h1: begin sr = sa - sb; e.lo = 16'(sr); e.hi = 16'h0; e.ovf = (sr > 32767) || (sr < -32768); end
      4'h2: begin e.lo = a & b; e.hi = 16'h0; end
      4'h3: begin e.lo = a | b; e.hi = 16'h0; end
      4'h4: begin e.lo = a << b[3:0]; e.hi = 16'h0; end
      4'h5: begin e.lo = a >> b[3:0]; e.hi = 16'h0; end
      4'h6: begin sr = sa >>> b[3:0]; e.lo = 16'(sr); e.hi = 16'h0; end
      4'h8: begin
        prod  = longint'(a) * longint'(b);
        e.lo  = prod[15:0];
        e.hi  = prod[31:16];
        e.lat = 5'd17;
      end
`ifdef ALU_EXEC_DIV_EN
      4'h9: begin
        if (b == 16'h0) begin
          e.lo = 16'hFFFF;
          e.hi = a;
          e.dz = 1'b1;
        end else begin
          e.lo  = a / b;
          e.hi  = a % b;
          e.lat = 5'd17;
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    if (!e.ill) begin
      e.wr   = 1'b1;
      e.dest = d;
    end
    e.zero = (e.lo == 16'h0);
    return e;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    expT src;
    bit  showNew;
    if (checkEn) begin
      if (acceptFlag) begin
        phase      = 0;
        acceptFlag = 1'b0;
      end else if (active) begin
        phase++;
      end
      if (active && phase > int'(pendE.lat)) begin
        heldE  = pendE;
        active = 1'b0;
      end
      showNew = active && (phase == int'(pendE.lat));
      src     = showNew ? pendE : heldE;
      chk("busy",     32'(busy),     32'(active));
      chk("done",     32'(done),     32'(showNew));
      chk("RegWrite", 32'(RegWrite), 32'(showNew && src.wr));
      chk("wrData",   32'(wrData),   32'(src.lo));
      chk("resultHi", 32'(resultHi), 32'(src.hi));
      chk("wrReg",    32'(wrReg),    32'(src.dest));
      chk("zero",     32'(zero),     32'(src.zero));
      chk("ovf",      32'(ovf),      32'(src.ovf));
      chk("divZero",  32'(divZero),  32'(src.dz));
      chk("illegal",  32'(illegal),  32'(src.ill));
    end
  end

  task automatic doReset();
    @(posedge clk);
    checkEn = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    start      = 1'b0;
    active     = 1'b0;
    acceptFlag = 1'b0;
    heldE      = '0;
    lastE      = '0;
    @(posedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    chk("rstData", {wrData, resultHi}, 32'h0);
    chk("rstCtl", 32'({busy, done, RegWrite, zero, ovf, divZero, illegal, wrReg}), 32'h0);
    reset = 1'b0;
  endtask

  // Issue one op, wait for done (bounded), optionally check literals.
  // litFlags = {RegWrite, zero, ovf, divZero, illegal} at the done cycle.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d, input bit lit, input logic [15:0] litLo,
                       input logic [15:0] litHi, input int litLat, input logic [4:0] litFlags,
                       input bit pulse);
    expT e;
    int  n;
    @(negedge clk);
    e       = model(op, a, b, d, lastE);
    lastE   = e;
    start   = 1'b1;
    aluOp   = op;
    op1     = a;
    op2     = b;
    destReg = d;
    @(posedge clk);
    pendE      = e;
    active     = 1'b1;
    acceptFlag = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    op1     = 16'h5A5A;
    op2     = 16'hA5A5;
    destReg = 4'hE;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (pulse && n == 3) begin
        start = 1'b1;
        aluOp = 4'h0;
        op1   = 16'h0001;
        op2   = 16'h0001;
      end
      if (pulse && n == 5) start = 1'b0;
    end
    chk("doneSeen", 32'(done), 32'h1);
    if (lit) begin
      chk("latency", n, litLat);
      chk("litWrData", 32'(wrData), 32'(litLo));
      chk("litResultHi", 32'(resultHi), 32'(litHi));
      chk("litFlags", 32'({RegWrite, zero, ovf, divZero, illegal}), 32'(litFlags));
      if (litFlags[4]) chk("litWrReg", 32'(wrReg), 32'(d));
    end
    $display("txn op=%h a=%h b=%h dest=%0d -> wrData=%h resultHi=%h RegWrite=%0b flags(z,o,dz,il)=%0b%0b%0b%0b lat=%0d",
             op, a, b, d, wrData, resultHi, RegWrite, zero, ovf, divZero, illegal, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    expT e;
    reset      = 1'b1;
    start      = 1'b0;
    aluOp      = 4'h0;
    op1        = 16'h0;
    op2        = 16'h0;
    destReg    = 4'h0;
    checkEn    = 1'b0;
    active     = 1'b0;
    acceptFlag = 1'b0;
    phase      = 0;
    heldE      = '0;
    pendE      = '0;
    lastE      = '0;
    doReset();
    repeat (2) @(negedge clk);

    // MUL aborted by reset a few cycles into the iteration.
    @(negedge clk);
    e       = model(4'h8, 16'hFFFF, 16'hFFFF, 4'h2, lastE);
    start   = 1'b1;
    aluOp   = 4'h8;
    op1     = 16'hFFFF;
    op2     = 16'hFFFF;
    destReg = 4'h2;
    @(posedge clk);
    pendE      = e;
    active     = 1'b1;
    acceptFlag = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midMulBusy", 32'(busy), 32'h1);
    doReset();
    $display("txn reset during MUL -> wrData=%h resultHi=%h busy=%0b", wrData, resultHi, busy);
    repeat (20) @(negedge clk);

    // op, a, b, dest, lit, litLo, litHi, litLat, litFlags, pulse
    issue(4'h0, 16'h7FFF, 16'h0001, 4'd3, 1'b1, 16'h8000, 16'h0000, 0,  5'b10100, 1'b0);
    issue(4'h1, 16'h1010, 16'h1010, 4'd4, 1'b1, 16'h0000, 16'h0000, 0,  5'b11000, 1'b0);
    issue(4'h8, 16'hFFFF, 16'hFFFF, 4'd5, 1'b1, 16'h0001, 16'hFFFE, 17, 5'b10000, 1'b1);
`ifdef ALU_EXEC_DIV_EN
    // 4112 / 3 = 1370 remainder 2
    issue(4'h9, 16'h1010, 16'h0003, 4'd6, 1'b1, 16'h055A, 16'h0002, 17, 5'b10000, 1'b0);
    issue(4'h9, 16'h1234, 16'h0000, 4'd7, 1'b1, 16'hFFFF, 16'h1234, 0,  5'b10010, 1'b0);
`else
    issue(4'h9, 16'h1010, 16'h0003, 4'd6, 1'b1, 16'h0001, 16'hFFFE, 0,  5'b00001, 1'b0);
    issue(4'h9, 16'h1234, 16'h0000, 4'd7, 1'b1, 16'h0001, 16'hFFFE, 0,  5'b00001, 1'b0);
`endif
    issue(4'h6, 16'h8000, 16'h0004, 4'd8, 1'b1, 16'hF800, 16'h0000, 0,  5'b10000, 1'b0);
    issue(4'h4, 16'h0001, 16'h000F, 4'd9, 1'b1, 16'h8000, 16'h0000, 0,  5'b10000, 1'b0);
    issue(4'hF, 16'h1111, 16'h2222, 4'd1, 1'b1, 16'h8000, 16'h0000, 0,  5'b00001, 1'b0);
`ifdef ALU_EXEC_DIV_EN
    issue(4'h9, 16'h0010, 16'h0002, 4'd2, 1'b1, 16'h0008, 16'h0000, 17, 5'b10000, 1'b0);
`else
    issue(4'h9, 16'h0010, 16'h0002, 4'd2, 1'b1, 16'h8000, 16'h0000, 0,  5'b00001, 1'b0);
`endif

    // Model-only vectors covering the remaining ops and corners.
    issue(4'h2, 16'hF0F0, 16'h3C3C, 4'd10, 1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h3, 16'hF0F0, 16'h0F0F, 4'd11, 1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h5, 16'h8000, 16'h0013, 4'd12, 1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h1, 16'h8000, 16'h0001, 4'd13, 1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h0, 16'h8000, 16'h8000, 4'd14, 1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h7, 16'h0001, 16'h0001, 4'd15, 1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h8, 16'h0003, 16'h0005, 4'd1,  1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h8, 16'h0000, 16'h1234, 4'd2,  1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h9, 16'hFFFF, 16'h00FF, 4'd3,  1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);
    issue(4'h6, 16'h4000, 16'h0021, 4'd4,  1'b0, 16'h0, 16'h0, 0, 5'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
